// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and helpers for the multi-cycle CPU datapath.
//   CPU_WIDTH  : default datapath word width used by the channel selectors
//   CPU_NUM_CH : default number of selector channels
//   clog2()    : constant ceil(log2(value)); clog2(1) = 0
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_WIDTH  = 6;
    localparam int CPU_NUM_CH = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. The search starts at ptr and
// wraps modulo NUM_CH, so the first requester at or after ptr wins.
//   req       in  [NUM_CH]  per-channel request
//   ptr       in  [SEL_W]   channel with highest priority this cycle (< NUM_CH)
//   gnt_valid out           some channel is granted
//   gnt_idx   out [SEL_W]   index of the granted channel (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    // Explicit wrap against NUM_CH so non-power-of-two channel counts never
    // depend on SEL_W overflow.
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NUM_CH) ? s - NUM_CH : s;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_valid && req[wrap_idx(int'(ptr), k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// -----------------------------------------------------------------------------
// mux_arb_n
// N-channel, WIDTH-bit registered selector with a one-entry valid/ready output
// register. Channel choice is round-robin (ROUND_ROBIN=1) or by control
// (ROUND_ROBIN=0). A pop and an accept in the same cycle overlap, giving one
// word per cycle.
//   CLK        in               clock, rising edge
//   Reset      in               synchronous reset, active-high
//   in_valid   in  [NUM_CH]     per-channel request
//   in_data    in  [NUM_CH*W]   channel i at [i*WIDTH +: WIDTH]
//   in_ready   out [NUM_CH]     per-channel accept, one-hot or zero
//   control    in  [SEL_W]      channel select (fixed mode only)
//   out_valid  out              output register holds data
//   out_data   out [WIDTH]      registered selected data
//   out_ch     out [SEL_W]      channel that supplied out_data
//   out_ready  in               consumer takes out_data this cycle
// -----------------------------------------------------------------------------
module mux_arb_n
    import cpu_pkg::*;
#(
    parameter int WIDTH       = CPU_WIDTH,
    parameter int NUM_CH      = CPU_NUM_CH,
    parameter int SEL_W       = clog2(CPU_NUM_CH),
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        control,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic              rr_valid;
    logic [SEL_W-1:0]  rr_idx;
    logic              fx_valid;
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  sel_data;
    logic              space;
    logic              accept;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Fixed mode: compare against each legal index so an out-of-range
    // control never grants and never indexes past in_valid.
    always_comb begin
        fx_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (control == SEL_W'(i) && in_valid[i]) begin
                fx_valid = 1'b1;
            end
        end
    end

    assign grant_valid = ROUND_ROBIN ? rr_valid : fx_valid;
    assign grant_idx   = ROUND_ROBIN ? rr_idx   : control;

    assign space  = !out_valid_q || out_ready;
    assign accept = space && grant_valid;

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = accept;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (accept) begin
            // A pop in the same cycle is covered here: new data replaces old.
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
            ptr_d       = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order. The data
        // register is reset too, because out_data=0 after reset is visible.
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_n
// Directed bench for mux_arb_n. Three instances share the clock and reset:
//   u_rr4 : NUM_CH=4, SEL_W=2, round-robin
//   u_fx4 : NUM_CH=4, SEL_W=3, fixed select
//   u_rr3 : NUM_CH=3, SEL_W=2, round-robin
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_mux_arb_n;

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    // round-robin, 4 channels
    logic [3:0]  v4, rdy4;
    logic [23:0] d4;
    logic [1:0]  ctl4, oc4;
    logic        ov4, ordy4;
    logic [5:0]  od4;

    // fixed select, 4 channels, 3-bit control
    logic [3:0]  vf, rdyf;
    logic [23:0] df;
    logic [2:0]  ctlf, ocf;
    logic        ovf, ordyf;
    logic [5:0]  odf;

    // round-robin, 3 channels
    logic [2:0]  v3, rdy3;
    logic [17:0] d3;
    logic [1:0]  ctl3, oc3;
    logic        ov3, ordy3;
    logic [5:0]  od3;

    mux_arb_n #(.WIDTH(6), .NUM_CH(4), .SEL_W(2), .ROUND_ROBIN(1'b1)) u_rr4 (
        .CLK(CLK), .Reset(Reset), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
        .control(ctl4), .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(ordy4)
    );

    mux_arb_n #(.WIDTH(6), .NUM_CH(4), .SEL_W(3), .ROUND_ROBIN(1'b0)) u_fx4 (
        .CLK(CLK), .Reset(Reset), .in_valid(vf), .in_data(df), .in_ready(rdyf),
        .control(ctlf), .out_valid(ovf), .out_data(odf), .out_ch(ocf), .out_ready(ordyf)
    );

    mux_arb_n #(.WIDTH(6), .NUM_CH(3), .SEL_W(2), .ROUND_ROBIN(1'b1)) u_rr3 (
        .CLK(CLK), .Reset(Reset), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .control(ctl3), .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(ordy3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        v4 = '0; d4 = '0; ctl4 = '0; ordy4 = 1'b0;
        vf = '0; df = '0; ctlf = '0; ordyf = 1'b0;
        v3 = '0; d3 = '0; ctl3 = '0; ordy3 = 1'b0;
        step();
        step();
        Reset = 1'b0;

        check("rst_ov",  32'(ov4), 32'd0);
        check("rst_od",  32'(od4), 32'd0);
        check("rst_oc",  32'(oc4), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // 1. reset mid-transfer, with a would-be accept on the reset edge
        v4 = 4'b0001; d4 = {18'd0, 6'h2A}; ordy4 = 1'b0;
        step();
        check("t1_load_ov", 32'(ov4), 32'd1);
        check("t1_load_od", 32'(od4), 32'h2A);
        v4 = 4'b0010; d4 = {12'd0, 6'h11, 6'h2A}; ordy4 = 1'b1; Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t1_rst_ov", 32'(ov4), 32'd0);
        check("t1_rst_od", 32'(od4), 32'd0);
        check("t1_rst_oc", 32'(oc4), 32'd0);
        v4 = 4'b1111;
        #1;
        check("t1_ptr0_rdy", 32'(rdy4), 32'b0001);

        // 2. round-robin fairness, all requesting, consumer always ready
        d4 = {6'h04, 6'h03, 6'h02, 6'h01};
        ordy4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_rdy%0d", k), 32'(rdy4), 32'(4'b0001 << (k % 4)));
            step();
            check($sformatf("t2_ov%0d", k), 32'(ov4), 32'd1);
            check($sformatf("t2_oc%0d", k), 32'(oc4), 32'(k % 4));
            check($sformatf("t2_od%0d", k), 32'(od4), 32'((k % 4) + 1));
        end

        // 3. backpressure on channel 2
        v4 = 4'b0100; d4 = {6'h00, 6'h15, 6'h00, 6'h00}; ordy4 = 1'b1;
        #1;
        check("t3_rdy", 32'(rdy4), 32'b0100);
        step();
        check("t3_od", 32'(od4), 32'h15);
        check("t3_oc", 32'(oc4), 32'd2);
        ordy4 = 1'b0;
        d4 = {6'h00, 6'h2B, 6'h00, 6'h00};
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t3_stall_rdy%0d", k), 32'(rdy4), 32'd0);
            step();
            check($sformatf("t3_stall_ov%0d", k), 32'(ov4), 32'd1);
            check($sformatf("t3_stall_od%0d", k), 32'(od4), 32'h15);
            check($sformatf("t3_stall_oc%0d", k), 32'(oc4), 32'd2);
        end
        v4 = 4'b0000; ordy4 = 1'b1;
        step();
        check("t3_pop_ov", 32'(ov4), 32'd0);
        check("t3_pop_od", 32'(od4), 32'h15);
        check("t3_pop_oc", 32'(oc4), 32'd2);

        // 6. simultaneous pop and accept
        v4 = 4'b0001; d4 = {18'd0, 6'h2A}; ordy4 = 1'b1;
        step();
        check("t6_pre_od", 32'(od4), 32'h2A);
        v4 = 4'b0010; d4 = {12'd0, 6'h3F, 6'h00};
        #1;
        check("t6_rdy", 32'(rdy4), 32'b0010);
        step();
        check("t6_ov", 32'(ov4), 32'd1);
        check("t6_od", 32'(od4), 32'h3F);
        check("t6_oc", 32'(oc4), 32'd1);
        v4 = 4'b0000;

        // 4. fixed-select mode
        vf = 4'b1001; df = {6'h33, 6'h22, 6'h21, 6'h11}; ctlf = 3'd3; ordyf = 1'b1;
        #1;
        check("t4_rdy3", 32'(rdyf), 32'b1000);
        step();
        check("t4_ov", 32'(ovf), 32'd1);
        check("t4_od", 32'(odf), 32'h33);
        check("t4_oc", 32'(ocf), 32'd3);
        ctlf = 3'd1;
        #1;
        check("t4_rdy_noreq", 32'(rdyf), 32'd0);
        ctlf = 3'd0;
        #1;
        check("t4_rdy0", 32'(rdyf), 32'b0001);
        ctlf = 3'd5;
        #1;
        check("t4_rdy5", 32'(rdyf), 32'd0);
        step();
        check("t4_pop_ov", 32'(ovf), 32'd0);
        check("t4_pop_od", 32'(odf), 32'h33);
        check("t4_pop_oc", 32'(ocf), 32'd3);
        vf = '0;

        // 5. wrap with three channels
        v3 = 3'b010; d3 = {6'h00, 6'h07, 6'h00}; ordy3 = 1'b1;
        #1;
        check("t5_rdy_a", 32'(rdy3), 32'b010);
        step();
        check("t5_oc_a", 32'(oc3), 32'd1);
        v3 = 3'b011; d3 = {6'h00, 6'h0B, 6'h0A};
        #1;
        check("t5_rdy_b", 32'(rdy3), 32'b001);
        step();
        check("t5_oc_b", 32'(oc3), 32'd0);
        check("t5_od_b", 32'(od3), 32'h0A);
        check("t5_rdy_c", 32'(rdy3), 32'b010);
        step();
        check("t5_oc_c", 32'(oc3), 32'd1);
        check("t5_od_c", 32'(od3), 32'h0B);
        check("t5_ov_c", 32'(ov3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
